// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding a UART frame serialiser.
// Frame: start(0), 8 data bits LSB-first, optional even parity, one stop(1).
// Optional feature macro: UART_TX_FIFO_OVF_EN adds a sticky overflow flag
// (ovf) with a clear input (ovf_clr).
// Outputs tx/tx_busy/tx_done are registered from the FSM state, so the line
// lags the state register by one clock.
module uart_tx_fifo #(
  parameter int CLK_PER_BIT = 5208,
  parameter int DEPTH       = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     parity_en,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
`ifdef UART_TX_FIFO_OVF_EN
  input  logic                     ovf_clr,
  output logic                     ovf,
`endif
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     tx,
  output logic                     tx_busy,
  output logic                     tx_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(CLK_PER_BIT);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  // FIFO storage and bookkeeping
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count, w_cnt_nxt;
  logic          r_full, r_empty;

  // Serialiser state
  state_t        r_state;
  logic [CW-1:0] r_bit_cnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift;
  logic          r_par_en, r_par_bit;
  logic          r_tx, r_busy, r_done;

  logic          w_bit_last, w_pop, w_wr;
  logic [7:0]    w_head;

  assign w_bit_last = (r_bit_cnt == CW'(CLK_PER_BIT - 1));
  // The FSM pops either from idle or on the final stop cycle (back-to-back).
  assign w_pop  = !r_empty && ((r_state == S_IDLE) || (r_state == S_STOP && w_bit_last));
  // A write while full is dropped even if a pop frees a slot on this edge.
  assign w_wr   = wr_en && !r_full;
  assign w_head = r_mem[r_rd_ptr];

  // Next occupancy from the accepted write / pop pair
  always_comb begin
    w_cnt_nxt = r_count;
    if (w_wr && !w_pop)      w_cnt_nxt = r_count + (AW+1)'(1);
    else if (!w_wr && w_pop) w_cnt_nxt = r_count - (AW+1)'(1);
  end

  // Storage array: contents need no reset, occupancy governs validity
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= wr_data;
  end

  // Pointers and registered occupancy flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_cnt_nxt;
      r_full  <= (w_cnt_nxt == (AW+1)'(DEPTH));
      r_empty <= (w_cnt_nxt == '0);
    end
  end

  // Frame FSM with registered line, busy and done outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= '0;
      r_idx     <= '0;
      r_shift   <= '0;
      r_par_en  <= 1'b0;
      r_par_bit <= 1'b0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_busy <= (r_state != S_IDLE);
      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (w_pop) begin
            r_shift   <= w_head;
            r_par_en  <= parity_en;
            r_par_bit <= ^w_head;
            r_bit_cnt <= '0;
            r_state   <= S_START;
          end
        end
        S_START: begin
          r_tx <= 1'b0;
          if (w_bit_last) begin
            r_bit_cnt <= '0;
            r_idx     <= '0;
            r_state   <= S_DATA;
          end else begin
            r_bit_cnt <= r_bit_cnt + CW'(1);
          end
        end
        S_DATA: begin
          r_tx <= r_shift[0];
          if (w_bit_last) begin
            r_bit_cnt <= '0;
            r_shift   <= {1'b0, r_shift[7:1]};
            if (r_idx == 3'd7) r_state <= r_par_en ? S_PARITY : S_STOP;
            else               r_idx   <= r_idx + 3'd1;
          end else begin
            r_bit_cnt <= r_bit_cnt + CW'(1);
          end
        end
        S_PARITY: begin
          r_tx <= r_par_bit;
          if (w_bit_last) begin
            r_bit_cnt <= '0;
            r_state   <= S_STOP;
          end else begin
            r_bit_cnt <= r_bit_cnt + CW'(1);
          end
        end
        S_STOP: begin
          r_tx <= 1'b1;
          if (w_bit_last) begin
            r_done    <= 1'b1;
            r_bit_cnt <= '0;
            if (w_pop) begin
              r_shift   <= w_head;
              r_par_en  <= parity_en;
              r_par_bit <= ^w_head;
              r_state   <= S_START;
            end else begin
              r_state   <= S_IDLE;
            end
          end else begin
            r_bit_cnt <= r_bit_cnt + CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef UART_TX_FIFO_OVF_EN
  logic r_ovf;
  // Sticky overflow: a drop on the same edge as a clear wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               r_ovf <= 1'b0;
    else if (wr_en && r_full) r_ovf <= 1'b1;
    else if (ovf_clr)         r_ovf <= 1'b0;
  end
  assign ovf = r_ovf;
`endif

  assign full    = r_full;
  assign empty   = r_empty;
  assign count   = r_count;
  assign tx      = r_tx;
  assign tx_busy = r_busy;
  assign tx_done = r_done;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: frame-level reference model compared every cycle,
// a behavioural UART receiver scoreboard, and literal timing checks on a trace.
module tb_uart_tx_fifo;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int TRN   = 8192;

  logic       clk = 1'b0, rst_n = 1'b0, parity_en = 1'b0, wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       full, empty, tx, tx_busy, tx_done;
  logic [2:0] count;
`ifdef UART_TX_FIFO_OVF_EN
  logic       ovf, ovf_clr = 1'b0;
`endif

  int checks = 0, fails = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  uart_tx_fifo #(.CLK_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .parity_en(parity_en), .wr_en(wr_en), .wr_data(wr_data),
`ifdef UART_TX_FIFO_OVF_EN
    .ovf_clr(ovf_clr), .ovf(ovf),
`endif
    .full(full), .empty(empty), .count(count), .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h cyc=%0d", nm, act, exp, cyc);
    end
  endtask

  // ---------------- reference model (frame time = FSM time) ----------------
  typedef struct { bit par; logic [7:0] d; } fr_t;
  logic [7:0] q[$];
  fr_t        sb[$];
  bit         busyF = 0;
  int         fcyc = 0, flen = 10;
  bit         fbits [11];
  logic       e_tx = 1, e_busy = 0, e_done = 0, m_ovf = 0;
  int         e_count = 0, m_sz;
  bit         m_wr, m_pop, m_last;
  logic [7:0] m_d;

  task automatic load_frame(input logic [7:0] d, input bit p);
    fr_t f;
    fbits[0] = 0;
    for (int i = 0; i < 8; i++) fbits[i+1] = d[i];
    if (p) begin fbits[9] = ^d; fbits[10] = 1; flen = 11; end
    else   begin fbits[9] = 1;  fbits[10] = 1; flen = 10; end
    f.par = p; f.d = d;
    sb.push_back(f);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete(); sb.delete();
      busyF = 0; fcyc = 0;
      e_tx = 1; e_busy = 0; e_done = 0; e_count = 0; m_ovf = 0;
    end else begin
      m_sz   = q.size();
      m_last = busyF && (fcyc == flen*CPB - 1);
      m_wr   = wr_en && (m_sz < DEPTH);
      m_pop  = (m_sz > 0) && (!busyF || m_last);
      e_tx   = busyF ? fbits[fcyc/CPB] : 1'b1;
      e_busy = busyF;
      e_done = m_last;
`ifdef UART_TX_FIFO_OVF_EN
      if (wr_en && m_sz == DEPTH) m_ovf = 1;
      else if (ovf_clr)           m_ovf = 0;
`endif
      if (busyF && !m_last) fcyc++;
      else if (m_pop) begin
        m_d = q.pop_front();
        load_frame(m_d, parity_en);
        busyF = 1; fcyc = 0;
      end else busyF = 0;
      if (m_wr) q.push_back(wr_data);
      e_count = q.size();
    end
  end

  always @(posedge clk) cyc++;

  // ---------------- trace, per-cycle compare, receiver ----------------
  logic tr_tx [TRN], tr_done [TRN], tr_busy [TRN], tr_empty [TRN];
  bit         rx_act = 0;
  int         rx_k, rx_len, rx_frames = 0;
  fr_t        rx_f;
  logic [10:0] rx_bits;
  logic [7:0] rx_last = 8'h00;

  always @(negedge clk) begin
    if (cyc < TRN) begin
      tr_tx[cyc] = tx; tr_done[cyc] = tx_done; tr_busy[cyc] = tx_busy; tr_empty[cyc] = empty;
    end
    chk("tx", tx, e_tx);
    chk("tx_busy", tx_busy, e_busy);
    chk("tx_done", tx_done, e_done);
    chk("count", count, e_count);
    chk("full", full, (e_count == DEPTH));
    chk("empty", empty, (e_count == 0));
`ifdef UART_TX_FIFO_OVF_EN
    chk("ovf", ovf, m_ovf);
`endif
    if (!rst_n) rx_act = 0;
    else begin
      if (!rx_act && tx === 1'b0) begin
        chk("rx_frame_expected", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          rx_act = 1; rx_k = 0; rx_f = sb[0]; rx_len = rx_f.par ? 11 : 10;
        end
      end
      if (rx_act) begin
        if (rx_k % CPB == CPB/2) rx_bits[rx_k/CPB] = tx;
        if (rx_k == (rx_len-1)*CPB + CPB/2) begin
          chk("rx_start", rx_bits[0], 0);
          chk("rx_data", rx_bits[8:1], rx_f.d);
          if (rx_f.par) chk("rx_parity", rx_bits[9], ^rx_f.d);
          chk("rx_stop", rx_bits[rx_len-1], 1);
          rx_last = rx_bits[8:1];
          rx_frames++;
          void'(sb.pop_front());
          rx_act = 0;
        end
        rx_k++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic wr(input logic [7:0] d);
    wr_en = 1; wr_data = d; tick(1); wr_en = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    for (int i = 0; i < 2000 && n < 2; i++) begin
      tick(1);
      if (!tx_busy && empty) n++; else n = 0;
    end
    chk("idle_reached", n >= 2, 1);
  endtask

  initial begin
    int k, f, f2, dc, bc, fr0;
    logic [9:0] obs;

    tick(3);
    chk("rst_tx", tx, 1); chk("rst_empty", empty, 1); chk("rst_count", count, 0);
    rst_n = 1;
    tick(2);

    // single 0xA5 frame without parity
    wait_idle();
    parity_en = 0; k = cyc; wr(8'hA5); tick(50);
    f = k + 3;
    chk("t1_latency_hi", tr_tx[f-1], 1);
    chk("t1_latency_lo", tr_tx[f], 0);
    for (int i = 0; i < 10; i++) obs[i] = tr_tx[f + i*CPB + CPB/2];
    chk("t1_bits", obs, 10'b1101001010);
    dc = 0;
    for (int i = f; i <= f + 45; i++) dc += int'(tr_done[i]);
    chk("t1_done_once", dc, 1);
    chk("t1_done_at40", tr_done[f+39], 1);
    chk("t1_busy_last", tr_busy[f+39], 1);
    chk("t1_busy_drop", tr_busy[f+40], 0);

    // parity frames 0x07 then 0x03, parity_en wiggled mid-frame
    wait_idle();
    parity_en = 1; k = cyc; wr(8'h07); wr(8'h03);
    tick(10); parity_en = 0; tick(10); parity_en = 1; tick(80); parity_en = 0;
    f = k + 3; f2 = f + 44;
    chk("t2_par1", tr_tx[f + 9*CPB + CPB/2], 1);
    chk("t2_stop1", tr_tx[f + 10*CPB + CPB/2], 1);
    chk("t2_done1", tr_done[f+43], 1);
    chk("t2_start2", tr_tx[f2], 0);
    chk("t2_par2", tr_tx[f2 + 9*CPB + CPB/2], 0);
    chk("t2_done2", tr_done[f2+43], 1);

    // overflow while the FSM is busy
    wait_idle();
    fr0 = rx_frames;
    wr(8'h11); tick(3);
    for (int i = 0; i < 6; i++) wr(8'h20 + 8'(i));
    chk("t3_full", full, 1);
    chk("t3_count", count, DEPTH);
`ifdef UART_TX_FIFO_OVF_EN
    chk("t3_ovf", ovf, 1);
    wr_en = 1; ovf_clr = 1; tick(1); wr_en = 0;
    chk("t3_ovf_drop_and_clr", ovf, 1);
    tick(1); ovf_clr = 0;
    chk("t3_ovf_cleared", ovf, 0);
`endif
    wait_idle();
    chk("t3_frames", rx_frames - fr0, 5);
    chk("t3_last", rx_last, 8'h23);

    // three back-to-back frames
    wait_idle();
    k = cyc; wr(8'h5A); wr(8'hC3); wr(8'h0F); tick(125);
    f = k + 3;
    chk("t4_done1", tr_done[f+39], 1);
    chk("t4_start2", tr_tx[f+40], 0);
    chk("t4_done2", tr_done[f+79], 1);
    chk("t4_start3", tr_tx[f+80], 0);
    chk("t4_done3", tr_done[f+119], 1);
    chk("t4_empty_before", tr_empty[f+78], 0);
    chk("t4_empty_after", tr_empty[f+79], 1);
    bc = 0;
    for (int i = f; i < f + 120; i++) bc += int'(tr_busy[i]);
    chk("t4_busy_contig", bc, 120);
    chk("t4_busy_end", tr_busy[f+120], 0);

    // reset during DATA with bytes queued
    wait_idle();
    wr(8'h81); wr(8'h42); wr(8'h99); tick(12);
    rst_n = 0; #1;
    chk("t5_tx", tx, 1); chk("t5_count", count, 0);
    chk("t5_empty", empty, 1); chk("t5_busy", tx_busy, 0);
    tick(2); rst_n = 1; tick(2);
    fr0 = rx_frames;
    wr(8'h3C); tick(48);
    chk("t5_frames", rx_frames - fr0, 1);
    chk("t5_byte", rx_last, 8'h3C);

    // randomized traffic: varying write rate, parity toggles, overflow clears
    for (int i = 0; i < 2000; i++) begin
      wr_en   = (i < 1000) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 0);
      wr_data = 8'($urandom);
      if ($urandom_range(0, 19) == 0) parity_en = ~parity_en;
`ifdef UART_TX_FIFO_OVF_EN
      ovf_clr = ($urandom_range(0, 15) == 0);
`endif
      tick(1);
    end
    wr_en = 0;
`ifdef UART_TX_FIFO_OVF_EN
    ovf_clr = 0;
`endif
    wait_idle();
    tick(4);
    chk("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
